// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//
// MM:SS.cc countdown timer for six active-low 7-segment digits.
//
// It loads a start value from the switches and counts it down in
// centisecond steps. It flags expiry at 00:00.00.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous reset, active low
//   load        one-cycle strobe: load set_min/set_sec (clamped), go IDLE
//   start_stop  one-cycle strobe: start / pause / resume
//   set_min     start minutes, binary, clamped to 99
//   set_sec     start seconds, binary, clamped to 59
//   seg0..seg5  active-low gfedcba digits, cs units .. min tens (registered)
//   running     high while counting
//   expired     high once the count has reached 00:00.00
// -----------------------------------------------------------------------------
module countdown_timer #(
  parameter int TICK_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       start_stop,
  input  logic [6:0] set_min,
  input  logic [5:0] set_sec,
  output logic [6:0] seg0,
  output logic [6:0] seg1,
  output logic [6:0] seg2,
  output logic [6:0] seg3,
  output logic [6:0] seg4,
  output logic [6:0] seg5,
  output logic       running,
  output logic       expired
);

  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  logic [1:0]    state_reg, state_next;
  logic [6:0]    cs_reg, cs_next;
  logic [5:0]    sec_reg, sec_next;
  logic [6:0]    min_reg, min_next;
  logic [PW-1:0] pre_reg, pre_next;

  logic time_zero;
  logic last_step;

  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign time_zero = (min_reg == 7'd0) && (sec_reg == 6'd0) && (cs_reg == 7'd0);
  // The one remaining centisecond: the decrement on this tick lands on zero.
  assign last_step = (min_reg == 7'd0) && (sec_reg == 6'd0) && (cs_reg == 7'd1);

  always_comb begin
    state_next = state_reg;
    cs_next    = cs_reg;
    sec_next   = sec_reg;
    min_next   = min_reg;
    pre_next   = pre_reg;

    if (load) begin
      min_next   = (set_min > 7'd99) ? 7'd99 : set_min;
      sec_next   = (set_sec > 6'd59) ? 6'd59 : set_sec;
      cs_next    = 7'd0;
      pre_next   = '0;
      state_next = IDLE;
    end else if (start_stop) begin
      // The prescaler holds on the strobe edge, so a resumed run
      // continues exactly where the partial tick stopped.
      case (state_reg)
        IDLE:    if (!time_zero) state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = state_reg;
      endcase
    end else if (state_reg == RUN) begin
      if (pre_reg == TICK_LAST) begin
        pre_next = '0;
        if (cs_reg != 7'd0) begin
          cs_next = cs_reg - 7'd1;
        end else begin
          cs_next = 7'd99;
          if (sec_reg != 6'd0) begin
            sec_next = sec_reg - 6'd1;
          end else begin
            // RUN is never entered with time zero, so min is non-zero here.
            sec_next = 6'd59;
            min_next = min_reg - 7'd1;
          end
        end
        if (last_step) state_next = DONE;
      end else begin
        pre_next = pre_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cs_reg    <= 7'd0;
      sec_reg   <= 6'd0;
      min_reg   <= 7'd0;
      pre_reg   <= '0;
      running   <= 1'b0;
      expired   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cs_reg    <= cs_next;
      sec_reg   <= sec_next;
      min_reg   <= min_next;
      pre_reg   <= pre_next;
      running   <= (state_next == RUN);
      expired   <= (state_next == DONE);
    end
  end

  // The display follows the counters one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seg0 <= SEG_ZERO;
      seg1 <= SEG_ZERO;
      seg2 <= SEG_ZERO;
      seg3 <= SEG_ZERO;
      seg4 <= SEG_ZERO;
      seg5 <= SEG_ZERO;
    end else begin
      seg0 <= seg_encode(4'(cs_reg % 7'd10));
      seg1 <= seg_encode(4'(cs_reg / 7'd10));
      seg2 <= seg_encode(4'(sec_reg % 6'd10));
      seg3 <= seg_encode(4'(sec_reg / 6'd10));
      seg4 <= seg_encode(4'(min_reg % 7'd10));
      seg5 <= seg_encode(4'(min_reg / 7'd10));
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//
// Directed bench for countdown_timer with TICK_CYCLES = 4.
//
// The reference model keeps the remaining time as a single count of
// centiseconds. It derives the expected digits from that count arithmetically.
// The outputs are compared against the model on every falling edge.
// Literal expectations pin the model at the interesting points.
// -----------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int TICK = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic       start_stop = 1'b0;
  logic [6:0] set_min = 7'd0;
  logic [5:0] set_sec = 6'd0;
  logic [6:0] seg0, seg1, seg2, seg3, seg4, seg5;
  logic       running, expired;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  countdown_timer #(.TICK_CYCLES(TICK)) dut (
    .clk(clk), .rst(rst), .load(load), .start_stop(start_stop),
    .set_min(set_min), .set_sec(set_sec),
    .seg0(seg0), .seg1(seg1), .seg2(seg2), .seg3(seg3), .seg4(seg4), .seg5(seg5),
    .running(running), .expired(expired)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
  int m_t    = 0;   // remaining time in centiseconds
  int m_pre  = 0;
  int m_st   = M_IDLE;
  int m_disp = 0;   // time currently shown on the display

  function automatic int clamp_total(input int mn, input int sc);
    int a, b;
    a = (mn > 99) ? 99 : mn;
    b = (sc > 59) ? 59 : sc;
    return a * 6000 + b * 100;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_t <= 0; m_pre <= 0; m_st <= M_IDLE; m_disp <= 0;
    end else begin
      m_disp <= m_t;
      if (load) begin
        m_t <= clamp_total(int'(set_min), int'(set_sec));
        m_pre <= 0;
        m_st <= M_IDLE;
      end else if (start_stop) begin
        if (m_st == M_IDLE && m_t != 0) m_st <= M_RUN;
        else if (m_st == M_RUN) m_st <= M_PAUSE;
        else if (m_st == M_PAUSE) m_st <= M_RUN;
      end else if (m_st == M_RUN) begin
        if (m_pre == TICK - 1) begin
          m_pre <= 0;
          m_t <= m_t - 1;
          if (m_t == 1) m_st <= M_DONE;
        end else begin
          m_pre <= m_pre + 1;
        end
      end
    end
  end

  function automatic logic [6:0] enc(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;  default: return 7'b1111111;
    endcase
  endfunction

  // Digit k (0 = cs units .. 5 = min tens) of a time given in centiseconds.
  function automatic logic [6:0] exp_seg(input int t, input int k);
    int v;
    case (k / 2)
      0: v = t % 100;
      1: v = (t / 100) % 60;
      default: v = t / 6000;
    endcase
    return (k % 2 == 0) ? enc(v % 10) : enc(v / 10);
  endfunction

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  // Compare process: every falling edge, every output.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("seg0", seg0, exp_seg(m_disp, 0));
      chk("seg1", seg1, exp_seg(m_disp, 1));
      chk("seg2", seg2, exp_seg(m_disp, 2));
      chk("seg3", seg3, exp_seg(m_disp, 3));
      chk("seg4", seg4, exp_seg(m_disp, 4));
      chk("seg5", seg5, exp_seg(m_disp, 5));
      chk("running", {6'd0, running}, {6'd0, m_st == M_RUN});
      chk("expired", {6'd0, expired}, {6'd0, m_st == M_DONE});
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input int mn, input int sc);
    set_min = 7'(mn); set_sec = 6'(sc); load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    $display("txn load %0d:%0d", mn, sc);
  endtask

  task automatic do_ss();
    start_stop = 1'b1;
    @(negedge clk);
    start_stop = 1'b0;
    $display("txn start_stop");
  endtask

  initial begin
    // Reset, checked without any clock edge.
    #2 rst = 1'b0;
    #1;
    chk("rst_seg0", seg0, 7'b1000000);
    chk("rst_seg5", seg5, 7'b1000000);
    chk("rst_running", {6'd0, running}, 7'd0);
    chk("rst_expired", {6'd0, expired}, 7'd0);
    chk_en = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(10);
    chk("idle_seg2", seg2, 7'b1000000);

    // Borrow chain: 01:00 -> 00:59.99 after one tick.
    do_load(1, 0);
    do_ss();
    cyc(4);
    cyc(1);
    chk("borrow_seg5", seg5, 7'b1000000);
    chk("borrow_seg4", seg4, 7'b1000000);
    chk("borrow_seg3", seg3, 7'b0010010);
    chk("borrow_seg2", seg2, 7'b0010000);
    chk("borrow_seg1", seg1, 7'b0010000);
    chk("borrow_seg0", seg0, 7'b0010000);

    // Expiry: 00:01 = 100 ticks = 400 cycles after the start edge.
    do_load(0, 1);
    do_ss();
    cyc(399);
    chk("exp_pre_running", {6'd0, running}, 7'd1);
    chk("exp_pre_expired", {6'd0, expired}, 7'd0);
    cyc(1);
    chk("exp_expired", {6'd0, expired}, 7'd1);
    chk("exp_running", {6'd0, running}, 7'd0);
    cyc(1);
    chk("exp_seg0", seg0, 7'b1000000);
    chk("exp_seg2", seg2, 7'b1000000);
    cyc(1000);
    do_ss();
    cyc(2);
    chk("exp_ss_ignored", {6'd0, expired}, 7'd1);

    // Pause / resume.
    do_load(0, 1);
    do_ss();
    cyc(42);
    do_ss();
    cyc(1);
    chk("pause_seg1", seg1, 7'b0010000);
    chk("pause_seg0", seg0, 7'b1000000);
    cyc(100);
    chk("pause_hold_seg1", seg1, 7'b0010000);
    chk("pause_running", {6'd0, running}, 7'd0);
    do_ss();
    cyc(1);
    chk("resume_before_seg0", seg0, 7'b1000000);
    cyc(2);
    chk("resume_seg0", seg0, 7'b0010000);
    chk("resume_seg1", seg1, 7'b0000000);

    // Clamp and priority.
    do_load(120, 63);
    cyc(1);
    chk("clamp_seg5", seg5, 7'b0010000);
    chk("clamp_seg4", seg4, 7'b0010000);
    chk("clamp_seg3", seg3, 7'b0010010);
    chk("clamp_seg2", seg2, 7'b0010000);
    chk("clamp_seg1", seg1, 7'b1000000);
    set_min = 7'd3; set_sec = 6'd0; load = 1'b1; start_stop = 1'b1;
    @(negedge clk);
    load = 1'b0; start_stop = 1'b0;
    $display("txn load+start_stop");
    chk("prio_running", {6'd0, running}, 7'd0);
    do_load(0, 0);
    do_ss();
    cyc(3);
    chk("zero_start_running", {6'd0, running}, 7'd0);

    // Reload during RUN.
    do_load(0, 5);
    do_ss();
    cyc(13);
    do_load(0, 2);
    chk("reload_running", {6'd0, running}, 7'd0);
    cyc(1);
    chk("reload_seg2", seg2, 7'b0100100);
    chk("reload_seg0", seg0, 7'b1000000);
    do_ss();
    cyc(3);
    chk("reload_pre_clear_seg0", seg0, 7'b1000000);
    cyc(2);
    chk("reload_first_step_seg0", seg0, 7'b0010000);

    // Reload from DONE.
    cyc(800);
    chk("done_expired", {6'd0, expired}, 7'd1);
    do_load(0, 1);
    chk("done_reload_expired", {6'd0, expired}, 7'd0);

    // Reset asserted mid-run, checked without a clock edge.
    do_load(1, 0);
    do_ss();
    cyc(10);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_seg1", seg1, 7'b1000000);
    chk("mid_rst_seg3", seg3, 7'b1000000);
    chk("mid_rst_running", {6'd0, running}, 7'd0);
    chk("mid_rst_expired", {6'd0, expired}, 7'd0);
    cyc(2);
    rst = 1'b1;
    cyc(10);
    chk("post_rst_seg4", seg4, 7'b1000000);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
